// File: rtl/game_timer_ctrl_if.sv
// game_timer_ctrl_if
//   Bundles the game timer's command inputs and its display/status outputs.
//   master : drives clk_1Hz and the command pulses, reads the mm:ss digits
//            and the status flags (game FSM / display side).
//   slave  : the timer itself.
//   Signals: clk_1Hz, start, pause, finish, penalty (commands);
//            sec_ones, sec_tens, min_ones, min_tens (BCD mm:ss);
//            running, time_up, state (status).
interface game_timer_ctrl_if;
  logic       clk_1Hz;
  logic       start;
  logic       pause;
  logic       finish;
  logic       penalty;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       running;
  logic       time_up;
  logic [1:0] state;

  modport master (
    output clk_1Hz, start, pause, finish, penalty,
    input  sec_ones, sec_tens, min_ones, min_tens, running, time_up, state
  );

  modport slave (
    input  clk_1Hz, start, pause, finish, penalty,
    output sec_ones, sec_tens, min_ones, min_tens, running, time_up, state
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl
//   Elapsed-time clock for the puzzle. Rising edges of the divided clk_1Hz
//   level add one second each; penalty pulses queue PENALTY_SEC extra
//   seconds that are drained one per cycle while running. Reaching
//   LIMIT_MIN:59 freezes the clock in DONE and raises a sticky time_up.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    game_timer_ctrl_if.slave (commands in, BCD digits/status out)
module game_timer_ctrl #(
  parameter int unsigned LIMIT_MIN   = 59,
  parameter int unsigned PENALTY_SEC = 10
) (
  input  logic               clk,
  input  logic               reset,
  game_timer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [2:0] LIM_TENS = 3'(LIMIT_MIN / 10);
  localparam logic [3:0] LIM_ONES = 4'(LIMIT_MIN % 10);

  state_t     state_q, state_d;
  logic       prev;
  logic       tick;
  logic [7:0] pending_q, pending_d;
  logic [3:0] sec_ones_q, sec_ones_d, min_ones_q, min_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d, min_tens_q, min_tens_d;
  logic       time_up_q, time_up_d;

  // Command decode with priority start > finish > pause > penalty.
  logic do_start, do_finish, do_pause, do_penalty;
  logic counting, inc, dec, limit_hit;
  logic [3:0] so_inc, mo_inc;
  logic [2:0] st_inc, mt_inc;
  logic [8:0] pen_sum;

  assign tick       = bus.clk_1Hz & ~prev;
  assign do_start   = bus.start;
  assign do_finish  = !do_start && bus.finish && (state_q == RUN || state_q == PAUSED);
  assign do_pause   = !do_start && !do_finish && bus.pause &&
                      (state_q == RUN || state_q == PAUSED);
  assign do_penalty = !do_start && !do_finish && !do_pause && bus.penalty && (state_q == RUN);

  // A cycle that carries an accepted command is spent on the command: the
  // digits freeze on finish and do not advance on the pause edge itself.
  assign counting = (state_q == RUN) && !do_start && !do_finish && !do_pause;
  assign inc      = counting && (tick || pending_q != 8'd0);
  // The tick's second wins; a queued penalty second waits for a free cycle.
  assign dec      = counting && !tick && pending_q != 8'd0;

  // BCD ripple increment of mm:ss. min_tens needs no wrap because the
  // limit stops counting before it could pass LIMIT_MIN/10.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    so_inc = sec_ones_q + 4'd1;
    st_inc = sec_tens_q;
    mo_inc = min_ones_q;
    mt_inc = min_tens_q;
    if (sec_ones_q == 4'd9) begin
      so_inc = 4'd0;
      st_inc = sec_tens_q + 3'd1;
      if (sec_tens_q == 3'd5) begin
        st_inc = 3'd0;
        mo_inc = min_ones_q + 4'd1;
        if (min_ones_q == 4'd9) begin
          mo_inc = 4'd0;
          mt_inc = min_tens_q + 3'd1;
        end
      end
    end
  end

  assign limit_hit = inc && mt_inc == LIM_TENS && mo_inc == LIM_ONES &&
                     st_inc == 3'd5 && so_inc == 4'd9;

  // Saturating penalty add, with this cycle's drain folded in.
  assign pen_sum = {1'b0, pending_q} + 9'(PENALTY_SEC) - {8'd0, dec};

  // Datapath next values.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    pending_d  = pending_q;
    time_up_d  = time_up_q;
    if (do_start) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 3'd0;
      min_ones_d = 4'd0;
      min_tens_d = 3'd0;
      pending_d  = 8'd0;
      time_up_d  = 1'b0;
    end else if (do_finish) begin
      pending_d = 8'd0;
    end else begin
      if (inc) begin
        sec_ones_d = so_inc;
        sec_tens_d = st_inc;
        min_ones_d = mo_inc;
        min_tens_d = mt_inc;
      end
      if (limit_hit) begin
        pending_d = 8'd0;
        time_up_d = 1'b1;
      end else if (do_penalty) begin
        pending_d = (pen_sum > 9'd255) ? 8'hFF : pen_sum[7:0];
      end else if (dec) begin
        pending_d = pending_q - 8'd1;
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    if (do_start)       state_d = RUN;
    else if (do_finish) state_d = DONE;
    else if (do_pause)  state_d = (state_q == RUN) ? PAUSED : RUN;
    else if (limit_hit) state_d = DONE;
  end

  // FSM: outputs.
  always_comb begin
    bus.running = (state_q == RUN);
    bus.state   = state_q;
  end

  // prev follows clk_1Hz in every state, so a level that rose while paused
  // is already absorbed by the time RUN resumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 3'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 3'd0;
      pending_q  <= 8'd0;
      time_up_q  <= 1'b0;
    end else begin
      prev       <= bus.clk_1Hz;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      pending_q  <= pending_d;
      time_up_q  <= time_up_d;
    end
  end

  assign bus.sec_ones = sec_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.min_ones = min_ones_q;
  assign bus.min_tens = min_tens_q;
  assign bus.time_up  = time_up_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl
//   Directed bench for game_timer_ctrl with LIMIT_MIN=1, PENALTY_SEC=10.
//   The stimulus thread pushes hand-computed expectations into a scoreboard
//   queue; a monitor thread pops and compares them at the next falling
//   clock edge (or immediately on sample_ev, for the async reset).
module tb_game_timer_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10, S_DONE = 2'b11;

  logic clk = 1'b0;
  logic reset;
  game_timer_ctrl_if bus ();

  game_timer_ctrl #(.LIMIT_MIN(1), .PENALTY_SEC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [13:0] digits;  // {min_tens, min_ones, sec_tens, sec_ones}
    logic [1:0]  st;
    logic        tu;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  function automatic logic [13:0] mmss(input int m, input int s);
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compares {digits, state, time_up, running}.
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      if (sb_q.size() > 0) begin
        exp_t e;
        logic [31:0] act, req;
        e   = sb_q.pop_front();
        act = {14'd0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
               bus.state, bus.time_up, bus.running};
        req = {14'd0, e.digits, e.st, e.tu, (e.st == S_RUN)};
        check(e.name, act, req);
      end
    end
  end

  task automatic expect_now(input string name, input int m, input int s,
                            input logic [1:0] st, input logic tu);
    exp_t e;
    e.name = name; e.digits = mmss(m, s); e.st = st; e.tu = tu;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising clk edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sec_edges(input int n);
    repeat (n) begin
      bus.clk_1Hz = 1'b1;
      cycles(5);
      bus.clk_1Hz = 1'b0;
      cycles(5);
    end
  endtask

  task automatic pulse(input logic s, input logic f, input logic p, input logic pen);
    bus.start = s; bus.finish = f; bus.pause = p; bus.penalty = pen;
    cycles(1);
    bus.start = 1'b0; bus.finish = 1'b0; bus.pause = 1'b0; bus.penalty = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.clk_1Hz = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.finish = 1'b0; bus.penalty = 1'b0;
    cycles(3);
    expect_now("reset_state", 0, 0, S_IDLE, 1'b0);
    wait_drain();
    reset = 1'b0;
    cycles(2);

    // Counting and carry chain.
    pulse(1, 0, 0, 0);
    sec_edges(12);
    expect_now("count_12", 0, 12, S_RUN, 1'b0);
    wait_drain();
    sec_edges(48);
    expect_now("carry_60", 1, 0, S_RUN, 1'b0);
    wait_drain();

    // Async reset mid-run with penalty seconds still queued (01:05, pending 5).
    pulse(0, 0, 0, 1);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    expect_now("async_reset", 0, 0, S_IDLE, 1'b0);
    #1 ->sample_ev;
    wait_drain();
    reset = 1'b0;
    cycles(1);
    pulse(1, 0, 0, 0);
    cycles(30);
    expect_now("pending_cleared", 0, 0, S_RUN, 1'b0);
    wait_drain();

    // Pause / resume, including clk_1Hz held high across the resume.
    sec_edges(5);
    expect_now("pre_pause", 0, 5, S_RUN, 1'b0);
    wait_drain();
    pulse(0, 0, 1, 0);
    sec_edges(3);
    expect_now("paused_hold", 0, 5, S_PAUSED, 1'b0);
    wait_drain();
    bus.clk_1Hz = 1'b1;
    cycles(3);
    pulse(0, 0, 1, 0);
    cycles(5);
    expect_now("no_stale_tick", 0, 5, S_RUN, 1'b0);
    wait_drain();
    bus.clk_1Hz = 1'b0;
    cycles(5);
    sec_edges(1);
    expect_now("resume_count", 0, 6, S_RUN, 1'b0);
    wait_drain();

    // Penalty bursts.
    sec_edges(14);
    expect_now("pre_penalty", 0, 20, S_RUN, 1'b0);
    wait_drain();
    pulse(0, 0, 0, 1);
    repeat (4) @(posedge clk);
    #1 expect_now("burst_rate", 0, 24, S_RUN, 1'b0);
    wait_drain();
    cycles(10);
    expect_now("penalty_10", 0, 30, S_RUN, 1'b0);
    wait_drain();
    pulse(0, 0, 0, 1);
    cycles(2);
    bus.clk_1Hz = 1'b1;
    cycles(5);
    bus.clk_1Hz = 1'b0;
    cycles(15);
    expect_now("burst_tick", 0, 41, S_RUN, 1'b0);
    wait_drain();
    pulse(0, 0, 0, 1);
    cycles(2);
    pulse(0, 0, 0, 1);
    cycles(30);
    expect_now("double_penalty", 1, 1, S_RUN, 1'b0);
    wait_drain();

    // Time limit 01:59.
    sec_edges(57);
    expect_now("pre_limit", 1, 58, S_RUN, 1'b0);
    wait_drain();
    sec_edges(1);
    expect_now("limit_hit", 1, 59, S_DONE, 1'b1);
    wait_drain();
    sec_edges(3);
    pulse(0, 0, 0, 1);
    cycles(15);
    expect_now("frozen_after_limit", 1, 59, S_DONE, 1'b1);
    wait_drain();
    pulse(1, 0, 0, 0);
    expect_now("restart", 0, 0, S_RUN, 1'b0);
    wait_drain();

    // Coincident commands while paused: start wins.
    sec_edges(3);
    pulse(0, 0, 1, 0);
    expect_now("paused2", 0, 3, S_PAUSED, 1'b0);
    wait_drain();
    pulse(1, 1, 1, 0);
    expect_now("start_wins", 0, 0, S_RUN, 1'b0);
    wait_drain();

    // finish in RUN at 01:10 with 7 seconds pending.
    sec_edges(67);
    expect_now("pre_finish", 1, 7, S_RUN, 1'b0);
    wait_drain();
    pulse(0, 0, 0, 1);
    cycles(3);
    pulse(0, 1, 0, 0);
    expect_now("finish_freeze", 1, 10, S_DONE, 1'b0);
    wait_drain();
    cycles(20);
    sec_edges(2);
    expect_now("finish_hold", 1, 10, S_DONE, 1'b0);
    wait_drain();
    pulse(1, 0, 0, 0);
    cycles(20);
    expect_now("pending_dropped", 0, 0, S_RUN, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
